// File: rtl/ritc_multi_dac_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ritc_multi_dac_loader
//  Description : Holds NCHAN x NDACS DAC words and serially shifts every
//                chain into its RITC DAC on request, all chains in lockstep.
//                User and servo write ports feed the storage. A single-entry
//                pending-load slot and a programmable SCLK divider are
//                included.
//  Option      : RITC_DAC_READBACK_EN - capture DAC_DOUT during each load
//                into a readback array visible on rb_dat_o.
//  Ports       : clk_i/rst_i (async active-high), user_* write/read port,
//                servo_* write port (fixed DAC index SERVO_ADDR), load_i /
//                chan_mask_i load request, busy_o/pending_o/wr_err_o status,
//                rb_dat_o readback, DAC_DOUT/DAC_DIN/DAC_CLOCK/DAC_LATCH pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module ritc_multi_dac_loader #(
    parameter int NCHAN      = 2,
    parameter int NDACS      = 33,
    parameter int DAC_BITS   = 12,   // must be >= 2
    parameter int CLKDIV     = 0,
    parameter int SERVO_ADDR = 31,
    localparam int CW  = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    localparam int AW  = (NDACS > 1) ? $clog2(NDACS) : 1,
    localparam int BW  = $clog2(DAC_BITS + 1),
    localparam int DVW = (CLKDIV > 0) ? $clog2(CLKDIV + 1) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                user_wr_i,
    input  logic [CW-1:0]       user_chan_i,
    input  logic [AW-1:0]       user_dac_i,
    input  logic [DAC_BITS-1:0] user_dat_i,
    output logic [DAC_BITS-1:0] user_dat_o,
    input  logic                servo_wr_i,
    input  logic [CW-1:0]       servo_chan_i,
    input  logic [DAC_BITS-1:0] servo_dat_i,
    input  logic                load_i,
    input  logic [NCHAN-1:0]    chan_mask_i,
    output logic                busy_o,
    output logic                pending_o,
    output logic                wr_err_o,
    output logic [DAC_BITS-1:0] rb_dat_o,
    input  logic [NCHAN-1:0]    DAC_DOUT,
    output logic [NCHAN-1:0]    DAC_DIN,
    output logic [NCHAN-1:0]    DAC_CLOCK,
    output logic [NCHAN-1:0]    DAC_LATCH
);

    localparam logic [DVW-1:0] DIV_LAST  = DVW'(CLKDIV);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(DAC_BITS - 1);
    localparam logic [AW-1:0]  IDX_LAST  = AW'(NDACS - 1);
    localparam logic [AW-1:0]  SERVO_IDX = AW'(SERVO_ADDR);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_LATCH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                         state_q, state_d;
    logic [AW-1:0]                  idx_q, idx_d;
    logic [BW-1:0]                  bit_q, bit_d;
    logic [DVW-1:0]                 div_q, div_d;
    logic [NCHAN-1:0]               mask_q, mask_d;
    logic                           pend_q, pend_d;
    logic [NCHAN-1:0]               pmask_q, pmask_d;
    logic [NCHAN-1:0][DAC_BITS-1:0] sh_q;
    logic [NCHAN-1:0]               din_q, sclk_q, lat_q;
    logic                           wrerr_q;
    logic [DAC_BITS-1:0]            udat_q;
    logic [DAC_BITS-1:0]            mem_q [NCHAN][NDACS];

    // ------------------------------------------------------------------
    // Storage: no reset, servo has priority over the user port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (servo_wr_i) begin
            mem_q[servo_chan_i][SERVO_IDX] <= servo_dat_i;
        end else if (user_wr_i) begin
            mem_q[user_chan_i][user_dac_i] <= user_dat_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrerr_q <= 1'b0;
            udat_q  <= '0;
        end else begin
            wrerr_q <= wrerr_q | (servo_wr_i & user_wr_i);
            udat_q  <= mem_q[user_chan_i][user_dac_i];
        end
    end

    // ------------------------------------------------------------------
    // Load sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        div_d   = div_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        pmask_d = pmask_q;
        case (state_q)
            S_IDLE: begin
                if (load_i) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    mask_d  = chan_mask_i;
                end
            end
            S_FETCH: begin
                state_d = S_LO;
                bit_d   = '0;
                div_d   = '0;
            end
            S_LO: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_HI;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q != BIT_LAST) begin
                        state_d = S_LO;
                        bit_d   = bit_q + 1'b1;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_FETCH;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_DONE: begin
                // A request arriving in DONE behaves exactly like a queued one.
                if (load_i || pend_q) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    mask_d  = load_i ? chan_mask_i : pmask_q;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Requests during an active load merge into one pending slot;
        // the most recent mask wins.
        if (load_i && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            pend_d  = 1'b1;
            pmask_d = chan_mask_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            mask_q  <= '0;
            pend_q  <= 1'b0;
            pmask_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            pmask_q <= pmask_d;
        end
    end

    // ------------------------------------------------------------------
    // Pin registers, derived from the next state so each pin is valid for
    // exactly the cycles the sequencer spends in the matching state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q   <= '0;
            din_q  <= '0;
            sclk_q <= '0;
            lat_q  <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                sclk_q[c] <= mask_d[c] & (state_d == S_HI);
                lat_q[c]  <= mask_d[c] & (state_d == S_LATCH);
                if (state_q == S_FETCH) begin
                    // Word snapshot: later storage writes do not disturb it.
                    sh_q[c]  <= mem_q[c][idx_q];
                    din_q[c] <= mask_d[c] & mem_q[c][idx_q][DAC_BITS-1];
                end else if ((state_q == S_HI) && (state_d == S_LO)) begin
                    // Falling SCLK: present the next bit.
                    sh_q[c]  <= sh_q[c] << 1;
                    din_q[c] <= mask_d[c] & sh_q[c][DAC_BITS-2];
                end else if ((state_d == S_LATCH) || (state_d == S_DONE) ||
                             (state_d == S_IDLE)) begin
                    din_q[c] <= 1'b0;
                end
            end
        end
    end

`ifdef RITC_DAC_READBACK_EN
    logic [NCHAN-1:0][DAC_BITS-1:0] cap_q;
    logic [DAC_BITS-1:0]            rb_q [NCHAN][NDACS];
    logic [DAC_BITS-1:0]            rbo_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_q <= '0;
            rbo_q <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                for (int k = 0; k < NDACS; k++) begin
                    rb_q[c][k] <= '0;
                end
            end
        end else begin
            rbo_q <= rb_q[user_chan_i][user_dac_i];
            for (int c = 0; c < NCHAN; c++) begin
                // Sample on the same edge that raises SCLK.
                if ((state_q == S_LO) && (state_d == S_HI)) begin
                    cap_q[c] <= {cap_q[c][DAC_BITS-2:0], DAC_DOUT[c]};
                end
                // idx has already advanced at FETCH; at LATCH it still
                // points at the last word.
                if ((state_q == S_FETCH) && (idx_q != '0)) begin
                    rb_q[c][idx_q - 1'b1] <= cap_q[c];
                end
                if (state_q == S_LATCH) begin
                    rb_q[c][idx_q] <= cap_q[c];
                end
            end
        end
    end

    assign rb_dat_o = rbo_q;
`else
    logic w_unused_dout;
    assign w_unused_dout = ^DAC_DOUT;
    assign rb_dat_o      = '0;
`endif

    assign busy_o     = (state_q != S_IDLE);
    assign pending_o  = pend_q;
    assign wr_err_o   = wrerr_q;
    assign user_dat_o = udat_q;
    assign DAC_DIN    = din_q;
    assign DAC_CLOCK  = sclk_q;
    assign DAC_LATCH  = lat_q;

endmodule
`default_nettype wire

// File: tb/tb_ritc_multi_dac_loader.sv
`default_nettype none
module tb_ritc_multi_dac_loader;

    localparam int A_NDACS = 33;
    localparam int A_BITS  = 12;
    localparam int A_LOAD  = A_NDACS * (1 + 2 * A_BITS) + 1 + 1;
    localparam int B_NCHAN = 3;
    localparam int B_NDACS = 5;
    localparam int B_BITS  = 8;
    localparam int B_DIV   = 3;
    localparam int B_SERVO = 2;
    localparam int B_LOAD  = B_NDACS * (1 + 2 * B_BITS * (B_DIV + 1)) + (B_DIV + 1) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: default parameters ----------------
    logic        a_user_wr = 0, a_servo_wr = 0, a_load = 0;
    logic [0:0]  a_user_chan = 0, a_servo_chan = 0;
    logic [5:0]  a_user_dac = 0;
    logic [11:0] a_user_dat = 0, a_servo_dat = 0, a_udat, a_rb;
    logic [1:0]  a_mask = 0, a_dout, a_din, a_dclk, a_latch;
    logic        a_busy, a_pend, a_wrerr;
    assign a_dout = a_din;

    ritc_multi_dac_loader u_a (
        .clk_i(clk), .rst_i(rst),
        .user_wr_i(a_user_wr), .user_chan_i(a_user_chan), .user_dac_i(a_user_dac),
        .user_dat_i(a_user_dat), .user_dat_o(a_udat),
        .servo_wr_i(a_servo_wr), .servo_chan_i(a_servo_chan), .servo_dat_i(a_servo_dat),
        .load_i(a_load), .chan_mask_i(a_mask),
        .busy_o(a_busy), .pending_o(a_pend), .wr_err_o(a_wrerr), .rb_dat_o(a_rb),
        .DAC_DOUT(a_dout), .DAC_DIN(a_din), .DAC_CLOCK(a_dclk), .DAC_LATCH(a_latch)
    );

    // ---------------- DUT B: 3 chains, divided SCLK ----------------
    logic        b_user_wr = 0, b_servo_wr = 0, b_load = 0;
    logic [1:0]  b_user_chan = 0, b_servo_chan = 0;
    logic [2:0]  b_user_dac = 0;
    logic [7:0]  b_user_dat = 0, b_servo_dat = 0, b_udat, b_rb;
    logic [2:0]  b_mask = 0, b_dout, b_din, b_dclk, b_latch;
    logic        b_busy, b_pend, b_wrerr;
    assign b_dout = b_din;

    ritc_multi_dac_loader #(
        .NCHAN(B_NCHAN), .NDACS(B_NDACS), .DAC_BITS(B_BITS), .CLKDIV(B_DIV), .SERVO_ADDR(B_SERVO)
    ) u_b (
        .clk_i(clk), .rst_i(rst),
        .user_wr_i(b_user_wr), .user_chan_i(b_user_chan), .user_dac_i(b_user_dac),
        .user_dat_i(b_user_dat), .user_dat_o(b_udat),
        .servo_wr_i(b_servo_wr), .servo_chan_i(b_servo_chan), .servo_dat_i(b_servo_dat),
        .load_i(b_load), .chan_mask_i(b_mask),
        .busy_o(b_busy), .pending_o(b_pend), .wr_err_o(b_wrerr), .rb_dat_o(b_rb),
        .DAC_DOUT(b_dout), .DAC_DIN(b_din), .DAC_CLOCK(b_dclk), .DAC_LATCH(b_latch)
    );

    // ---------------- reference storage ----------------
    logic [11:0] mdl_a [2][A_NDACS];
    logic [7:0]  mdl_b [3][B_NDACS];

    // ---------------- pin monitor state ----------------
    bit obs [3][2][0:511];
    int nob [3][2];
    int act [3][2];
    int lat_pulses [3];
    int hr [3], lr [3], lc [3];
    bit seen_fall [3];
    logic [2:0] pck, plat;
    int ld, busy_cnt, hi_bad, lo_bad, lat_bad, pend_seen;

    task automatic mon_clear();
        for (int c = 0; c < 3; c++) begin
            for (int l = 0; l < 2; l++) begin
                nob[c][l] = 0;
                act[c][l] = 0;
            end
            lat_pulses[c] = 0; hr[c] = 0; lr[c] = 0; lc[c] = 0; seen_fall[c] = 0;
        end
        pck = 0; plat = 0; ld = 0;
        busy_cnt = 0; hi_bad = 0; lo_bad = 0; lat_bad = 0; pend_seen = 0;
    endtask

    // One-cycle bookkeeping of the serial pins: bits taken at SCLK rising
    // edges, SCLK high/low and latch pulse lengths, activity per load.
    task automatic sample(input logic [2:0] din, input logic [2:0] dck, input logic [2:0] lat, input int div);
        bit lat_fell = 0;
        for (int c = 0; c < 3; c++) begin
            if (din[c] | dck[c] | lat[c]) act[c][ld] = 1;
            if (dck[c] && !pck[c]) begin
                if (nob[c][ld] < 512) obs[c][ld][nob[c][ld]] = din[c];
                nob[c][ld]++;
                if (seen_fall[c] && (lr[c] != div + 1) && (lr[c] != div + 2)) lo_bad++;
            end
            if (dck[c]) hr[c]++;
            else if (pck[c]) begin
                if (hr[c] != div + 1) hi_bad++;
                hr[c] = 0; lr[c] = 0; seen_fall[c] = 1;
            end
            if (!dck[c]) lr[c]++;
            if (lat[c]) begin
                lc[c]++;
                seen_fall[c] = 0;
            end else if (plat[c]) begin
                if (lc[c] != div + 1) lat_bad++;
                lat_pulses[c]++;
                lc[c] = 0;
                lat_fell = 1;
            end
        end
        pck = dck; plat = lat;
        if (lat_fell) ld = 1;
    endtask

    function automatic int a_stream_err(int c, int l);
        int e = 0;
        if (nob[c][l] != A_NDACS * A_BITS) e++;
        for (int k = 0; k < A_NDACS; k++)
            for (int b = 0; b < A_BITS; b++)
                if (obs[c][l][k * A_BITS + b] !== mdl_a[c][k][A_BITS - 1 - b]) e++;
        return e;
    endfunction

    function automatic int b_stream_err(int c);
        int e = 0;
        if (nob[c][0] != B_NDACS * B_BITS) e++;
        for (int k = 0; k < B_NDACS; k++)
            for (int b = 0; b < B_BITS; b++)
                if (obs[c][0][k * B_BITS + b] !== mdl_b[c][k][B_BITS - 1 - b]) e++;
        return e;
    endfunction

    // Load on DUT A with up to two extra load requests at given cycles.
    task automatic run_load_a(input logic [1:0] m, input int inj1, input logic [1:0] m1,
                              input int inj2, input logic [1:0] m2, input int budget);
        mon_clear();
        a_load = 1'b1; a_mask = m;
        @(negedge clk);
        a_load = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            sample({1'b0, a_din}, {1'b0, a_dclk}, {1'b0, a_latch}, 0);
            if (a_pend) pend_seen = 1;
            if (!a_busy) break;
            busy_cnt++;
            a_load = (cyc == inj1) || (cyc == inj2);
            if (cyc == inj1) a_mask = m1;
            if (cyc == inj2) a_mask = m2;
            @(negedge clk);
        end
        a_load = 1'b0;
    endtask

    task automatic run_load_b(input logic [2:0] m, input int budget);
        mon_clear();
        b_load = 1'b1; b_mask = m;
        @(negedge clk);
        b_load = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            sample(b_din, b_dclk, b_latch, B_DIV);
            if (!b_busy) break;
            busy_cnt++;
            @(negedge clk);
        end
    endtask

    // ================= tests =================
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({a_busy, a_pend, a_wrerr, a_din, a_dclk, a_latch, a_udat, a_rb} !== '0) begin
            bad++;
            $display("FAIL reset_a got=%0h exp=0", {a_busy, a_pend, a_wrerr, a_din, a_dclk, a_latch, a_udat, a_rb});
        end
        total++;
        if ({b_busy, b_pend, b_wrerr, b_din, b_dclk, b_latch, b_udat, b_rb} !== '0) begin
            bad++;
            $display("FAIL reset_b got=%0h exp=0", {b_busy, b_pend, b_wrerr, b_din, b_dclk, b_latch, b_udat, b_rb});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_storage();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < A_NDACS; k++) begin
                a_user_wr = 1'b1; a_user_chan = c[0:0]; a_user_dac = k[5:0];
                a_user_dat = (c == 0 && k == 0) ? 12'hA5C : 12'($urandom);
                mdl_a[c][k] = a_user_dat;
                @(negedge clk);
            end
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < B_NDACS; k++) begin
                b_user_wr = 1'b1; b_user_chan = c[1:0]; b_user_dac = k[2:0];
                b_user_dat = 8'($urandom);
                mdl_b[c][k] = b_user_dat;
                @(negedge clk);
            end
        a_user_wr = 1'b0; b_user_wr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            int c, k;
            c = (i == 0) ? 0 : int'($urandom_range(1, 0));
            k = (i == 0) ? 0 : int'($urandom_range(A_NDACS - 1, 0));
            a_user_chan = c[0:0]; a_user_dac = k[5:0];
            @(negedge clk);
            total++;
            if (a_udat !== mdl_a[c][k]) begin
                bad++;
                $display("FAIL user_read[%0d][%0d] got=%h exp=%h", c, k, a_udat, mdl_a[c][k]);
            end
        end
        total++;
        if (a_wrerr !== 1'b0) begin
            bad++;
            $display("FAIL wr_err_clean got=%b exp=0", a_wrerr);
        end
    endtask

    task automatic test_collision();
        // servo alone on chain 0
        a_servo_wr = 1'b1; a_servo_chan = 1'b0; a_servo_dat = 12'($urandom);
        mdl_a[0][31] = a_servo_dat;
        @(negedge clk);
        a_servo_wr = 1'b0;
        total++;
        if (a_wrerr !== 1'b0) begin
            bad++;
            $display("FAIL wr_err_servo_only got=%b exp=0", a_wrerr);
        end
        // simultaneous writes: servo wins
        a_user_wr = 1'b1; a_user_chan = 1'b1; a_user_dac = 6'd31; a_user_dat = 12'h111;
        a_servo_wr = 1'b1; a_servo_chan = 1'b1; a_servo_dat = 12'h7FF;
        mdl_a[1][31] = 12'h7FF;
        @(negedge clk);
        a_user_wr = 1'b0; a_servo_wr = 1'b0;
        total++;
        if (a_wrerr !== 1'b1) begin
            bad++;
            $display("FAIL wr_err_set got=%b exp=1", a_wrerr);
        end
        foreach (mdl_a[c]) begin
            a_user_chan = c[0:0]; a_user_dac = 6'd31;
            @(negedge clk);
            total++;
            if (a_udat !== mdl_a[c][31]) begin
                bad++;
                $display("FAIL collide_read[%0d] got=%h exp=%h", c, a_udat, mdl_a[c][31]);
            end
        end
        repeat (5) @(negedge clk);
        total++;
        if (a_wrerr !== 1'b1) begin
            bad++;
            $display("FAIL wr_err_sticky got=%b exp=1", a_wrerr);
        end
    endtask

    task automatic test_load_basic();
        logic [11:0] first;
        run_load_a(2'b11, -1, 2'b00, -1, 2'b00, 4000);
        for (int b = 0; b < 12; b++) first[11 - b] = obs[0][0][b];
        total++;
        if (first !== 12'hA5C) begin
            bad++;
            $display("FAIL first_word got=%h exp=a5c", first);
        end
        total++;
        if (busy_cnt != A_LOAD) begin
            bad++;
            $display("FAIL busy_len got=%0d exp=%0d", busy_cnt, A_LOAD);
        end
        for (int c = 0; c < 2; c++) begin
            total++;
            if (a_stream_err(c, 0) != 0) begin
                bad++;
                $display("FAIL stream_ch%0d got=%0d_errors exp=0 (bits=%0d)", c, a_stream_err(c, 0), nob[c][0]);
            end
            total++;
            if (lat_pulses[c] != 1) begin
                bad++;
                $display("FAIL latch_count_ch%0d got=%0d exp=1", c, lat_pulses[c]);
            end
        end
        total++;
        if ((hi_bad | lo_bad | lat_bad | pend_seen) != 0) begin
            bad++;
            $display("FAIL timing_basic got=hi%0d/lo%0d/lat%0d/pend%0d exp=0", hi_bad, lo_bad, lat_bad, pend_seen);
        end
    endtask

    task automatic test_back_to_back();
        // Two requests during the load; the second mask (01) wins.
        run_load_a(2'b11, 100, 2'b11, 200, 2'b01, 4000);
        total++;
        if (busy_cnt != 2 * A_LOAD) begin
            bad++;
            $display("FAIL b2b_busy_len got=%0d exp=%0d", busy_cnt, 2 * A_LOAD);
        end
        total++;
        if (pend_seen != 1) begin
            bad++;
            $display("FAIL b2b_pending got=%0d exp=1", pend_seen);
        end
        total++;
        if ((a_stream_err(0, 0) + a_stream_err(1, 0) + a_stream_err(0, 1)) != 0) begin
            bad++;
            $display("FAIL b2b_streams got=%0d_errors exp=0", a_stream_err(0, 0) + a_stream_err(1, 0) + a_stream_err(0, 1));
        end
        total++;
        if (act[1][1] != 0) begin
            bad++;
            $display("FAIL b2b_masked_ch1 got=%0d exp=0", act[1][1]);
        end
        total++;
        if (lat_pulses[0] != 2 || lat_pulses[1] != 1) begin
            bad++;
            $display("FAIL b2b_latches got=%0d/%0d exp=2/1", lat_pulses[0], lat_pulses[1]);
        end
        total++;
        if (a_pend !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pend_cleared got=%b exp=0", a_pend);
        end
        // Request landing exactly in the DONE cycle of the first load.
        run_load_a(2'b11, A_LOAD - 1, 2'b10, -1, 2'b00, 4000);
        total++;
        if (busy_cnt != 2 * A_LOAD) begin
            bad++;
            $display("FAIL done_req_busy_len got=%0d exp=%0d", busy_cnt, 2 * A_LOAD);
        end
        total++;
        if (act[0][1] != 0 || a_stream_err(1, 1) != 0) begin
            bad++;
            $display("FAIL done_req_second_load got=act%0d/err%0d exp=0/0", act[0][1], a_stream_err(1, 1));
        end
    endtask

    task automatic test_clkdiv();
        b_servo_wr = 1'b1; b_servo_chan = 2'd2; b_servo_dat = 8'($urandom);
        mdl_b[2][B_SERVO] = b_servo_dat;
        @(negedge clk);
        b_servo_wr = 1'b0;
        run_load_b(3'b101, 2000);
        total++;
        if (busy_cnt != B_LOAD) begin
            bad++;
            $display("FAIL div_busy_len got=%0d exp=%0d", busy_cnt, B_LOAD);
        end
        total++;
        if (hi_bad != 0 || lo_bad != 0) begin
            bad++;
            $display("FAIL div_sclk_runs got=hi%0d/lo%0d exp=0", hi_bad, lo_bad);
        end
        total++;
        if (lat_bad != 0 || lat_pulses[0] != 1 || lat_pulses[2] != 1) begin
            bad++;
            $display("FAIL div_latch got=bad%0d/%0d/%0d exp=0/1/1", lat_bad, lat_pulses[0], lat_pulses[2]);
        end
        total++;
        if (act[1][0] != 0) begin
            bad++;
            $display("FAIL div_masked_ch1 got=%0d exp=0", act[1][0]);
        end
        for (int c = 0; c < 3; c += 2) begin
            total++;
            if (b_stream_err(c) != 0) begin
                bad++;
                $display("FAIL div_stream_ch%0d got=%0d_errors exp=0", c, b_stream_err(c));
            end
        end
    endtask

    task automatic test_reset_midload();
        int lat_seen = 0;
        a_load = 1'b1; a_mask = 2'b11;
        @(negedge clk);
        a_load = 1'b0;
        // word 10, bit 5 high phase: 10*25 + 1 + 2*5 + 1
        repeat (262) @(negedge clk);
        total++;
        if (a_dclk !== 2'b11) begin
            bad++;
            $display("FAIL midload_sclk_high got=%b exp=11", a_dclk);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({a_din, a_dclk, a_latch, a_busy} !== '0) begin
            bad++;
            $display("FAIL midload_async_drop got=%h exp=0", {a_din, a_dclk, a_latch, a_busy});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_latch != 0) lat_seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_latch != 0) lat_seen++;
        end
        total++;
        if (lat_seen != 0 || a_wrerr !== 1'b0) begin
            bad++;
            $display("FAIL midload_no_latch got=lat%0d/err%b exp=0/0", lat_seen, a_wrerr);
        end
        run_load_a(2'b11, -1, 2'b00, -1, 2'b00, 4000);
        total++;
        if (busy_cnt != A_LOAD || a_stream_err(0, 0) != 0 || a_stream_err(1, 0) != 0) begin
            bad++;
            $display("FAIL reload_after_reset got=busy%0d/err%0d/%0d exp=%0d/0/0", busy_cnt,
                     a_stream_err(0, 0), a_stream_err(1, 0), A_LOAD);
        end
    endtask

    task automatic test_readback();
        int e = 0;
        logic [11:0] exp;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < A_NDACS; k++) begin
                a_user_chan = c[0:0]; a_user_dac = k[5:0];
                @(negedge clk);
`ifdef RITC_DAC_READBACK_EN
                exp = mdl_a[c][k];
`else
                exp = 12'h000;
`endif
                if (a_rb !== exp) e++;
            end
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL readback got=%0d_errors exp=0", e);
        end
    endtask

    initial begin
        test_reset();
        test_storage();
        test_collision();
        test_load_basic();
        test_back_to_back();
        test_clkdiv();
        test_reset_midload();
        test_readback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
